// File: rtl/comparador_pipe.sv
// comparador_pipe: two-stage pipelined sign-magnitude comparator.
// Stage 1 registers the operand pair with its sign normalised, so that
// negative zero compares equal to +0. Stage 2 registers the one-hot
// igual/maior/menor result. Both stages sit behind a valid/ready handshake.
// Optional feature: define CMP_MINMAX_EN to add a running min/max tracker of
// operand A. It updates on each output transfer.
module comparador_pipe #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic         sa,
   input  logic [W-1:0] b,
   input  logic         sb,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         igual,
   output logic         maior,
   output logic         menor
`ifdef CMP_MINMAX_EN
   ,
   input  logic         clr_mm,
   output logic         mm_valid,
   output logic [W-1:0] max_mag,
   output logic [W-1:0] min_mag,
   output logic         max_sign,
   output logic         min_sign
`endif
);

   // Sign of a zero magnitude is dropped so -0 and +0 share one encoding.
   function automatic logic norm_sign(input logic s, input logic [W-1:0] m);
      return s && (m != {W{1'b0}});
   endfunction

   // Ordering of two normalised sign-magnitude values, as {igual, maior, menor}.
   function automatic logic [2:0] cmp_sm(input logic s_x, input logic [W-1:0] m_x,
                                         input logic s_y, input logic [W-1:0] m_y);
      logic [2:0] r;
      if (s_x != s_y) begin
         r = s_x ? 3'b001 : 3'b010;
      end else if (m_x == m_y) begin
         r = 3'b100;
      end else if ((m_x > m_y) != s_x) begin
         // A larger magnitude is the larger value only when both are positive.
         r = 3'b010;
      end else begin
         r = 3'b001;
      end
      return r;
   endfunction

   logic         s1_valid_r;
   logic [W-1:0] s1_a_r;
   logic         s1_sa_r;
   logic [W-1:0] s1_b_r;
   logic         s1_sb_r;
   logic         out_valid_r;
   logic [2:0]   res_r;
   logic         s2_load_s;
   logic         s1_load_s;
   logic [2:0]   cmp_s;

   // Handshake: S2 frees up when empty or popping; S1 then follows it.
   always_comb begin
      s2_load_s = !out_valid_r || out_ready;
      s1_load_s = !s1_valid_r || s2_load_s;
      cmp_s     = cmp_sm(s1_sa_r, s1_a_r, s1_sb_r, s1_b_r);
   end

   assign in_ready  = s1_load_s;
   assign out_valid = out_valid_r;
   assign igual     = res_r[2];
   assign maior     = res_r[1];
   assign menor     = res_r[0];

   // Stage 1: capture and normalise the incoming operand pair.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_a_r     <= {W{1'b0}};
         s1_sa_r    <= 1'b0;
         s1_b_r     <= {W{1'b0}};
         s1_sb_r    <= 1'b0;
      end else if (s1_load_s) begin
         s1_valid_r <= in_valid;
         if (in_valid) begin
            s1_a_r  <= a;
            s1_sa_r <= norm_sign(sa, a);
            s1_b_r  <= b;
            s1_sb_r <= norm_sign(sb, b);
         end
      end
   end

   // Stage 2: register the compare result; hold while the consumer stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         res_r       <= 3'b000;
      end else if (s2_load_s) begin
         out_valid_r <= s1_valid_r;
         res_r       <= s1_valid_r ? cmp_s : 3'b000;
      end
   end

`ifdef CMP_MINMAX_EN
   logic [W-1:0] s2_a_r;
   logic         s2_sa_r;
   logic         mm_valid_r;
   logic [W-1:0] max_mag_r;
   logic         max_sign_r;
   logic [W-1:0] min_mag_r;
   logic         min_sign_r;
   logic         out_xfer_s;
   logic [2:0]   vs_max_s;
   logic [2:0]   vs_min_s;

   // Order the A travelling with the current result against the tracked extremes.
   always_comb begin
      out_xfer_s = out_valid_r && out_ready;
      vs_max_s   = cmp_sm(s2_sa_r, s2_a_r, max_sign_r, max_mag_r);
      vs_min_s   = cmp_sm(s2_sa_r, s2_a_r, min_sign_r, min_mag_r);
   end

   // Carry operand A alongside the stage-2 result for the tracker.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_a_r  <= {W{1'b0}};
         s2_sa_r <= 1'b0;
      end else if (s2_load_s) begin
         s2_a_r  <= s1_a_r;
         s2_sa_r <= s1_sa_r;
      end
   end

   // Running min/max of A; a clear coinciding with a transfer reseeds from that A.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mm_valid_r <= 1'b0;
         max_mag_r  <= {W{1'b0}};
         max_sign_r <= 1'b0;
         min_mag_r  <= {W{1'b0}};
         min_sign_r <= 1'b0;
      end else if (out_xfer_s && (clr_mm || !mm_valid_r)) begin
         mm_valid_r <= 1'b1;
         max_mag_r  <= s2_a_r;
         max_sign_r <= s2_sa_r;
         min_mag_r  <= s2_a_r;
         min_sign_r <= s2_sa_r;
      end else if (clr_mm) begin
         mm_valid_r <= 1'b0;
      end else if (out_xfer_s) begin
         if (vs_max_s[1]) begin
            max_mag_r  <= s2_a_r;
            max_sign_r <= s2_sa_r;
         end
         if (vs_min_s[0]) begin
            min_mag_r  <= s2_a_r;
            min_sign_r <= s2_sa_r;
         end
      end
   end

   assign mm_valid = mm_valid_r;
   assign max_mag  = max_mag_r;
   assign max_sign = max_sign_r;
   assign min_mag  = min_mag_r;
   assign min_sign = min_sign_r;
`endif

endmodule

// File: tb/tb_comparador_pipe.sv
// Directed testbench for comparador_pipe (W=4). Results are scored against a
// signed-integer reference model through an in-order expectation queue.
module tb_comparador_pipe;
   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic         sa;
   logic [W-1:0] b;
   logic         sb;
   logic         out_valid;
   logic         out_ready;
   logic         igual;
   logic         maior;
   logic         menor;
`ifdef CMP_MINMAX_EN
   logic         clr_mm;
   logic         mm_valid;
   logic [W-1:0] max_mag;
   logic [W-1:0] min_mag;
   logic         max_sign;
   logic         min_sign;
`endif

   int         n_checks = 0;
   int         n_pass   = 0;
   int         n_pops   = 0;
   logic [2:0] exp_q[$];
   logic       acc;

   comparador_pipe #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .sa        (sa),
      .b         (b),
      .sb        (sb),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .igual     (igual),
      .maior     (maior),
      .menor     (menor)
`ifdef CMP_MINMAX_EN
      ,
      .clr_mm    (clr_mm),
      .mm_valid  (mm_valid),
      .max_mag   (max_mag),
      .min_mag   (min_mag),
      .max_sign  (max_sign),
      .min_sign  (min_sign)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Reference: map each operand to a signed integer and compare numerically.
   function automatic logic [2:0] ref_cmp(input logic s_x, input logic [W-1:0] m_x,
                                          input logic s_y, input logic [W-1:0] m_y);
      int vx;
      int vy;
      vx = s_x ? -int'(m_x) : int'(m_x);
      vy = s_y ? -int'(m_y) : int'(m_y);
      if (vx == vy) return 3'b100;
      else if (vx > vy) return 3'b010;
      else return 3'b001;
   endfunction

   // One clock: drive at the falling edge, score the transfers, advance.
   task automatic run_cycle(input logic iv, input logic [9:0] pair, input logic ordy,
                            output logic accepted);
      logic [2:0] e;
      in_valid  = iv;
      {sa, a, sb, b} = pair;
      out_ready = ordy;
      #1;
      accepted = iv && in_ready;
      if (accepted) exp_q.push_back(ref_cmp(pair[9], pair[8:5], pair[4], pair[3:0]));
      if (out_valid && ordy) begin
         n_pops++;
         if (exp_q.size() == 0) begin
            check("unexpected_pop", 32'(out_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("result", 32'({igual, maior, menor}), 32'(e));
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [9:0] mk(input logic s_x, input logic [3:0] m_x,
                                     input logic s_y, input logic [3:0] m_y);
      return {s_x, m_x, s_y, m_y};
   endfunction

   // Single pair with the expected one-hot result written out by hand.
   task automatic directed(input string tag, input logic [9:0] pair, input logic [2:0] hand);
      check({tag, "_model"}, 32'(ref_cmp(pair[9], pair[8:5], pair[4], pair[3:0])), 32'(hand));
      run_cycle(1'b1, pair, 1'b1, acc);
      check({tag, "_acc"}, 32'(acc), 32'd1);
      check({tag, "_lat1"}, 32'(out_valid), 32'd0);
      run_cycle(1'b0, 10'd0, 1'b1, acc);
      check({tag, "_lat2"}, 32'({out_valid, igual, maior, menor}), 32'({1'b1, hand}));
      run_cycle(1'b0, 10'd0, 1'b1, acc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = 4'd0; sa = 1'b0; b = 4'd0; sb = 1'b0;
`ifdef CMP_MINMAX_EN
      clr_mm = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("rst_out", 32'({out_valid, igual, maior, menor}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_after", 32'({out_valid, igual, maior, menor}), 32'd0);

      // Equality, negative zero, sign handling and extreme magnitudes.
      directed("eq",      mk(1'b0, 4'd5, 1'b0, 4'd5),   3'b100);
      directed("negzero", mk(1'b1, 4'd0, 1'b0, 4'd0),   3'b100);
      directed("neg_pos", mk(1'b1, 4'd3, 1'b0, 4'd2),   3'b001);
      directed("zero_n7", mk(1'b0, 4'd0, 1'b1, 4'd7),   3'b010);
      directed("n9_n4",   mk(1'b1, 4'd9, 1'b1, 4'd4),   3'b001);
      directed("n2_n15",  mk(1'b1, 4'd2, 1'b1, 4'd15),  3'b010);
      directed("n15_p15", mk(1'b1, 4'd15, 1'b0, 4'd15), 3'b001);
      directed("p15_n15", mk(1'b0, 4'd15, 1'b1, 4'd15), 3'b010);
      directed("p7_p12",  mk(1'b0, 4'd7, 1'b0, 4'd12),  3'b001);

      // Streaming: 16 back-to-back pairs, results on consecutive cycles.
      n_pops = 0;
      for (int i = 0; i < 18; i++) begin
         logic [3:0] iv4;
         iv4 = 4'(i);
         run_cycle(i < 16, mk(iv4[0], iv4, iv4[1], 4'((i * 7) % 16)), 1'b1, acc);
         if (i < 16) check("stream_acc", 32'(acc), 32'd1);
         if (i >= 1 && i <= 16) check("stream_valid", 32'(out_valid), 32'd1);
         else check("stream_idle", 32'(out_valid), 32'd0);
      end
      check("stream_count", 32'(n_pops), 32'd16);
      check("stream_empty", 32'(exp_q.size()), 32'd0);

      // Back-pressure: out_ready low for 5 cycles while pushing.
      begin
         int p;
         p = 0;
         n_pops = 0;
         for (int k = 0; k < 5; k++) begin
            logic [3:0] pv;
            pv = 4'(p + 3);
            run_cycle(1'b1, mk(pv[0], pv, 1'b1, 4'd6), 1'b0, acc);
            if (acc) p++;
            check("bp_acc", 32'(acc), 32'(k < 2));
            if (k >= 1) begin
               check("bp_in_ready", 32'(in_ready), 32'd0);
               check("bp_hold", 32'({out_valid, igual, maior, menor}), 32'({1'b1, exp_q[0]}));
            end
         end
         for (int k = 0; k < 4; k++) run_cycle(1'b0, 10'd0, 1'b1, acc);
         check("bp_count", 32'(n_pops), 32'd2);
         check("bp_empty", 32'(exp_q.size()), 32'd0);
      end

      // Simultaneous pop and push while both stages are full.
      run_cycle(1'b1, mk(1'b0, 4'd1, 1'b0, 4'd2), 1'b0, acc);
      run_cycle(1'b1, mk(1'b1, 4'd1, 1'b0, 4'd2), 1'b0, acc);
      check("full_in_ready", 32'(in_ready), 32'd0);
      run_cycle(1'b1, mk(1'b0, 4'd9, 1'b0, 4'd2), 1'b1, acc);
      check("full_push_pop", 32'(acc), 32'd1);
      for (int k = 0; k < 3; k++) run_cycle(1'b0, 10'd0, 1'b1, acc);
      check("full_empty", 32'(exp_q.size()), 32'd0);

      // Reset with both stages full: outputs clear at once, nothing stale after.
      run_cycle(1'b1, mk(1'b0, 4'd8, 1'b0, 4'd1), 1'b0, acc);
      run_cycle(1'b1, mk(1'b1, 4'd8, 1'b0, 4'd1), 1'b0, acc);
      check("mid_full", 32'({out_valid, in_ready}), 32'b10);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_out", 32'({out_valid, igual, maior, menor}), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         run_cycle(1'b0, 10'd0, 1'b1, acc);
         check("mid_no_stale", 32'(out_valid), 32'd0);
      end
      directed("post_rst", mk(1'b1, 4'd1, 1'b1, 4'd1), 3'b100);

`ifdef CMP_MINMAX_EN
      clr_mm = 1'b1;
      run_cycle(1'b0, 10'd0, 1'b1, acc);
      clr_mm = 1'b0;
      run_cycle(1'b1, mk(1'b0, 4'd3, 1'b0, 4'd0), 1'b1, acc);
      run_cycle(1'b1, mk(1'b1, 4'd6, 1'b0, 4'd0), 1'b1, acc);
      run_cycle(1'b1, mk(1'b0, 4'd11, 1'b0, 4'd0), 1'b1, acc);
      run_cycle(1'b1, mk(1'b1, 4'd2, 1'b0, 4'd0), 1'b1, acc);
      for (int k = 0; k < 3; k++) run_cycle(1'b0, 10'd0, 1'b1, acc);
      check("mm_valid", 32'(mm_valid), 32'd1);
      check("mm_max", 32'({max_sign, max_mag}), 32'({1'b0, 4'd11}));
      check("mm_min", 32'({min_sign, min_mag}), 32'({1'b1, 4'd6}));
      clr_mm = 1'b1;
      run_cycle(1'b0, 10'd0, 1'b1, acc);
      clr_mm = 1'b0;
      check("mm_clr", 32'(mm_valid), 32'd0);
      run_cycle(1'b1, mk(1'b0, 4'd4, 1'b1, 4'd4), 1'b1, acc);
      for (int k = 0; k < 3; k++) run_cycle(1'b0, 10'd0, 1'b1, acc);
      check("mm_reseed_v", 32'(mm_valid), 32'd1);
      check("mm_reseed_max", 32'({max_sign, max_mag}), 32'({1'b0, 4'd4}));
      check("mm_reseed_min", 32'({min_sign, min_mag}), 32'({1'b0, 4'd4}));
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
